sd_xfer_sequencer: RTL and testbench

SD_XFER_SEQUENCER -- requirements
Module: sd_xfer_sequencer

---
 rtl/sd_seq_pkg.sv | 27 ++
 rtl/sd_xfer_sequencer_if.sv | 43 ++++
 rtl/sd_seq_timer.sv | 33 +++
 rtl/sd_xfer_sequencer.sv | 158 +++++++++++++++
 tb/tb_sd_xfer_sequencer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_seq_pkg.sv
// Shared definitions for the SD transfer sequencer: state encoding, error flag
// bit positions and the default stop-command index.
// Optional feature macro: SD_AUTO_CMD12_EN (adds the STOP_CMD / WAIT_STOP states).
package sd_seq_pkg;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StIssueCmd = 4'd1,
    StWaitCmd  = 4'd2,
    StIssueDat = 4'd3,
    StWaitDat  = 4'd4,
`ifdef SD_AUTO_CMD12_EN
    StStopCmd  = 4'd5,
    StWaitStop = 4'd6,
`endif
    StDone     = 4'd7,
    StError    = 4'd8
  } seq_state_e;

  // err_status bit positions
  localparam int unsigned ErrCmdTo = 0;
  localparam int unsigned ErrDatTo = 1;
  localparam int unsigned ErrAbort = 2;

  localparam logic [5:0] Cmd12Idx = 6'd12;

endpackage

// File: rtl/sd_xfer_sequencer_if.sv
// Handshake bundle between the register file / command and data controllers
// and the transfer sequencer. The sequencer uses the slave modport.
interface sd_xfer_sequencer_if #(
  parameter int unsigned TO_W = 16
);
  logic            start;
  logic            abort;
  logic [5:0]      cmd_index_i;
  logic [31:0]     argument_i;
  logic            data_present;
  logic            write_read_i;
  logic            multi_block;
  logic [15:0]     block_count_i;
  logic [TO_W-1:0] timeout_limit;
  logic            command_complete;
  logic            data_complete;

  logic            new_command;
  logic [5:0]      cmd_index_o;
  logic [31:0]     cmd_argument_o;
  logic            new_data;
  logic            write_read_o;
  logic            multiple_o;
  logic [15:0]     block_count_o;
  logic            busy;
  logic            xfer_done;
  logic [2:0]      err_status;

  modport master (
    output start, abort, cmd_index_i, argument_i, data_present, write_read_i,
           multi_block, block_count_i, timeout_limit, command_complete, data_complete,
    input  new_command, cmd_index_o, cmd_argument_o, new_data, write_read_o,
           multiple_o, block_count_o, busy, xfer_done, err_status
  );

  modport slave (
    input  start, abort, cmd_index_i, argument_i, data_present, write_read_i,
           multi_block, block_count_i, timeout_limit, command_complete, data_complete,
    output new_command, cmd_index_o, cmd_argument_o, new_data, write_read_o,
           multiple_o, block_count_o, busy, xfer_done, err_status
  );

endinterface

// File: rtl/sd_seq_timer.sv
// Saturating wait-state timeout counter. expired flags the cycle in which the
// count reaches the limit, so a limit of N allows exactly N wait cycles.
// A zero limit never expires.
module sd_seq_timer #(
  parameter int unsigned TO_W = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_inc;

  // Hold at all-ones instead of wrapping back to zero
  assign count_inc = (&count_q) ? count_q : count_q + TO_W'(1);
  assign expired   = enable && (limit != '0) && (count_inc == limit);

  // Count cycles spent in the current wait state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_inc;
    end
  end

endmodule

// File: rtl/sd_xfer_sequencer.sv
// SD transfer sequencer: issues the command, optional data phase and optional
// automatic stop command (CMD12), with per-wait timeouts and software abort.
// Optional feature macro: SD_AUTO_CMD12_EN.
module sd_xfer_sequencer
  import sd_seq_pkg::*;
#(
  parameter int unsigned TO_W      = 16,
  parameter logic [5:0]  CMD12_IDX = Cmd12Idx
) (
  input logic                clock,
  input logic                reset,
  sd_xfer_sequencer_if.slave bus
);

  seq_state_e  state_q, state_d;
  logic [2:0]  err_set;
  logic        in_wait;
  logic        expired;

  logic        new_command_q, new_data_q, busy_q, xfer_done_q;
  logic [5:0]  cmd_index_q;
  logic [31:0] cmd_arg_q;
  logic        dp_q, wr_q, mb_q;
  logic [15:0] bc_q;
  logic [2:0]  err_q;

`ifndef SD_AUTO_CMD12_EN
  logic [5:0] unused_cmd12;
  assign unused_cmd12 = CMD12_IDX;
`endif

  // Timer runs only in wait states; any other state clears it for the next entry
  always_comb begin
    in_wait = (state_q == StWaitCmd) || (state_q == StWaitDat);
`ifdef SD_AUTO_CMD12_EN
    in_wait = in_wait || (state_q == StWaitStop);
`endif
  end

  sd_seq_timer #(
    .TO_W (TO_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_wait),
    .enable  (in_wait),
    .limit   (bus.timeout_limit),
    .expired (expired)
  );

  // Next state and error flags; completes beat timeouts, abort beats everything
  always_comb begin
    state_d = state_q;
    err_set = '0;
    case (state_q)
      StIdle:     if (bus.start) state_d = StIssueCmd;
      StIssueCmd: state_d = StWaitCmd;
      StWaitCmd: begin
        if (bus.command_complete) begin
          state_d = (dp_q && (bc_q != '0)) ? StIssueDat : StDone;
        end else if (expired) begin
          state_d           = StError;
          err_set[ErrCmdTo] = 1'b1;
        end
      end
      StIssueDat: state_d = StWaitDat;
      StWaitDat: begin
        if (bus.data_complete) begin
`ifdef SD_AUTO_CMD12_EN
          state_d = mb_q ? StStopCmd : StDone;
`else
          state_d = StDone;
`endif
        end else if (expired) begin
          state_d           = StError;
          err_set[ErrDatTo] = 1'b1;
        end
      end
`ifdef SD_AUTO_CMD12_EN
      StStopCmd:  state_d = StWaitStop;
      StWaitStop: begin
        if (bus.command_complete) begin
          state_d = StDone;
        end else if (expired) begin
          state_d           = StError;
          err_set[ErrCmdTo] = 1'b1;
        end
      end
`endif
      StDone:     state_d = StIdle;
      StError:    state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    // ERROR always exits after one cycle even with abort still held
    if (bus.abort && (state_q != StIdle) && (state_q != StError)) begin
      state_d           = StError;
      err_set           = '0;
      err_set[ErrAbort] = 1'b1;
    end
  end

  // State register, registered pulse outputs and latched transaction fields
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      new_command_q <= 1'b0;
      new_data_q    <= 1'b0;
      busy_q        <= 1'b0;
      xfer_done_q   <= 1'b0;
      cmd_index_q   <= '0;
      cmd_arg_q     <= '0;
      dp_q          <= 1'b0;
      wr_q          <= 1'b0;
      mb_q          <= 1'b0;
      bc_q          <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
`ifdef SD_AUTO_CMD12_EN
      new_command_q <= (state_d == StIssueCmd) || (state_d == StStopCmd);
`else
      new_command_q <= (state_d == StIssueCmd);
`endif
      new_data_q    <= (state_d == StIssueDat);
      xfer_done_q   <= (state_d == StDone);
      busy_q        <= (state_d != StIdle);
      if ((state_q == StIdle) && bus.start) begin
        cmd_index_q <= bus.cmd_index_i;
        cmd_arg_q   <= bus.argument_i;
        dp_q        <= bus.data_present;
        wr_q        <= bus.write_read_i;
        mb_q        <= bus.multi_block;
        bc_q        <= bus.block_count_i;
        err_q       <= '0;
      end else begin
        err_q       <= err_q | err_set;
      end
`ifdef SD_AUTO_CMD12_EN
      if ((state_q != StStopCmd) && (state_d == StStopCmd)) begin
        cmd_index_q <= CMD12_IDX;
        cmd_arg_q   <= '0;
      end
`endif
    end
  end

  assign bus.new_command    = new_command_q;
  assign bus.cmd_index_o    = cmd_index_q;
  assign bus.cmd_argument_o = cmd_arg_q;
  assign bus.new_data       = new_data_q;
  assign bus.write_read_o   = wr_q;
  assign bus.multiple_o     = mb_q;
  assign bus.block_count_o  = bc_q;
  assign bus.busy           = busy_q;
  assign bus.xfer_done      = xfer_done_q;
  assign bus.err_status     = err_q;

endmodule

// File: tb/tb_sd_xfer_sequencer.sv
// Self-checking bench for sd_xfer_sequencer: a directed table, a few hand-written
// corner sequences and randomized transactions against a transaction-level model.
// Honors SD_AUTO_CMD12_EN when defined for the whole build.
module tb_sd_xfer_sequencer;

  localparam int unsigned TO_W = 16;
`ifdef SD_AUTO_CMD12_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif
  localparam int INF = 1000000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sd_xfer_sequencer_if #(.TO_W(TO_W)) bus ();

  sd_xfer_sequencer #(
    .TO_W      (TO_W),
    .CMD12_IDX (6'd12)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    bit          dp, wr, mb;
    logic [15:0] bc;
    int          lim, cd, dd, sd, ab;   // delays in wait cycles, 0 = never
    int          e_err, e_ncmd, e_ndat, e_done;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic [5:0] idx, input logic [31:0] arg,
                              input bit dp, input bit wr, input bit mb, input logic [15:0] bc,
                              input int lim, input int cd, input int dd, input int sd,
                              input int ab, input int e_err, input int e_ncmd,
                              input int e_ndat, input int e_done);
    vec_t v;
    v.idx = idx; v.arg = arg; v.dp = dp; v.wr = wr; v.mb = mb; v.bc = bc;
    v.lim = lim; v.cd = cd; v.dd = dd; v.sd = sd; v.ab = ab;
    v.e_err = e_err; v.e_ncmd = e_ncmd; v.e_ndat = e_ndat; v.e_done = e_done;
    return v;
  endfunction

  function automatic int inf0(input int x);
    return (x == 0) ? INF : x;
  endfunction

  // Transaction-level outcome: each wait resolves at the earliest of its
  // complete, timeout (limit) or abort; busy = issue + waits + done/error.
  function automatic void model(input vec_t v, output int err, output int ncmd,
                                output int ndat, output int ndone, output int blen);
    int to;
    to = inf0(v.lim);
    err = 0; ncmd = 1; ndat = 0; ndone = 0;
    if (inf0(v.cd) > to) begin
      err = 1; blen = v.lim + 2; return;
    end
    blen = 1 + v.cd;
    if (v.dp && (v.bc != 0)) begin
      ndat = 1;
      if (inf0(v.ab) <= inf0(v.dd) && inf0(v.ab) <= to) begin
        err = 4; blen += v.ab + 2; return;
      end
      if (inf0(v.dd) > to) begin
        err = 2; blen += v.lim + 2; return;
      end
      blen += 1 + v.dd;
      if (AUTO == 1 && v.mb) begin
        ncmd++;
        if (inf0(v.sd) > to) begin
          err = 1; blen += v.lim + 2; return;
        end
        blen += 1 + v.sd;
      end
    end
    ndone = 1;
    blen += 1;
  endfunction

  task automatic run_txn(input vec_t v, input int e_err, input int e_ncmd, input int e_ndat,
                         input int e_done, input int e_blen, input string tag);
    int ncmd = 0, ndat = 0, ndone = 0, blen = 0, fld_bad = 0;
    int cnt = -1, which = 0, last_cpl = -100, done_at = -1, idle_run = 0, cyc = 0, d;
    bit seen_busy = 0;
    logic [5:0]  exp_idx;
    logic [31:0] exp_arg;
    bus.cmd_index_i   = v.idx;
    bus.argument_i    = v.arg;
    bus.data_present  = v.dp;
    bus.write_read_i  = v.wr;
    bus.multi_block   = v.mb;
    bus.block_count_i = v.bc;
    bus.timeout_limit = TO_W'(v.lim);
    bus.start         = 1'b1;
    step();
    bus.start         = 1'b0;
    // Scramble the inputs to prove the fields were latched
    bus.cmd_index_i   = 6'($urandom);
    bus.argument_i    = $urandom;
    bus.data_present  = 1'($urandom);
    bus.write_read_i  = 1'($urandom);
    bus.multi_block   = 1'($urandom);
    bus.block_count_i = 16'($urandom);
    chk({tag, " err cleared by start"}, 64'(bus.err_status), 64'd0);
    exp_idx = v.idx;
    exp_arg = v.arg;
    while (cyc < 300 && idle_run < 3) begin
      bus.command_complete = 1'b0;
      bus.data_complete    = 1'b0;
      bus.abort            = 1'b0;
      if (bus.busy) begin blen++; seen_busy = 1; end
      if (bus.new_command) begin
        ncmd++;
        which = (ncmd == 1) ? 0 : 2;
        cnt   = 0;
        if (which == 2) begin exp_idx = 6'd12; exp_arg = '0; end
        if (bus.cmd_index_o !== exp_idx || bus.cmd_argument_o !== exp_arg) fld_bad++;
      end else if (bus.new_data) begin
        ndat++;
        which = 1;
        cnt   = 0;
        if (bus.block_count_o !== v.bc || bus.write_read_o !== v.wr ||
            bus.multiple_o !== v.mb) fld_bad++;
      end else if (cnt >= 0) begin
        cnt++;
        if (bus.busy && (bus.cmd_index_o !== exp_idx || bus.cmd_argument_o !== exp_arg))
          fld_bad++;
        d = (which == 0) ? v.cd : (which == 1) ? v.dd : v.sd;
        if (which == 1 && v.ab != 0 && cnt == v.ab) begin
          bus.abort = 1'b1;
          cnt = -1;
        end else if (d != 0 && cnt == d) begin
          if (which == 1) bus.data_complete = 1'b1;
          else bus.command_complete = 1'b1;
          last_cpl = cyc;
          cnt = -1;
        end
      end
      if (bus.xfer_done) begin ndone++; done_at = cyc; end
      if (seen_busy && !bus.busy) idle_run++;
      if (idle_run < 3) begin
        step();
        cyc++;
      end
    end
    bus.command_complete = 1'b0;
    bus.data_complete    = 1'b0;
    bus.abort            = 1'b0;
    chk({tag, " finished within bound"}, 64'(idle_run == 3), 64'd1);
    chk({tag, " err_status"}, 64'(bus.err_status), 64'(e_err));
    chk({tag, " new_command pulses"}, 64'(ncmd), 64'(e_ncmd));
    chk({tag, " new_data pulses"}, 64'(ndat), 64'(e_ndat));
    chk({tag, " xfer_done pulses"}, 64'(ndone), 64'(e_done));
    chk({tag, " busy cycles"}, 64'(blen), 64'(e_blen));
    chk({tag, " latched fields"}, 64'(fld_bad), 64'd0);
    if (ndone > 0) chk({tag, " done latency"}, 64'(done_at - last_cpl), 64'd1);
  endtask

  vec_t vecs[11];
  vec_t v;
  int   m_err, m_ncmd, m_ndat, m_done, m_blen;
  int   acc, blen_c, ncmd_c, done_c;

  initial begin
    bus.start = 0; bus.abort = 0; bus.cmd_index_i = '0; bus.argument_i = '0;
    bus.data_present = 0; bus.write_read_i = 0; bus.multi_block = 0;
    bus.block_count_i = '0; bus.timeout_limit = '0;
    bus.command_complete = 0; bus.data_complete = 0;

    //            idx    arg           dp wr mb bc  lim cd dd sd ab err   ncmd    ndat done
    vecs[0]  = mk(6'd7,  32'h0000_1234, 0, 0, 0, 1,  0, 5, 0, 0, 0, 0,    1,      0,   1);
    vecs[1]  = mk(6'd25, 32'hCAFE_F00D, 1, 1, 1, 2,  0, 3, 6, 4, 0, 0,    1+AUTO, 1,   1);
    vecs[2]  = mk(6'd17, 32'h0000_0001, 0, 0, 0, 0, 10, 0, 0, 0, 0, 1,    1,      0,   0);
    vecs[3]  = mk(6'd18, 32'h1111_2222, 1, 0, 0, 1,  8, 2, 8, 0, 0, 0,    1,      1,   1);
    vecs[4]  = mk(6'd3,  32'hA5A5_5A5A, 0, 0, 0, 0,  5, 5, 0, 0, 0, 0,    1,      0,   1);
    vecs[5]  = mk(6'd24, 32'h0BAD_BEEF, 1, 0, 1, 2,  6, 2, 7, 0, 0, 2,    1,      1,   0);
    vecs[6]  = mk(6'd18, 32'h0000_0400, 1, 0, 1, 4,  0, 2, 10, 3, 3, 4,   1,      1,   0);
    vecs[7]  = mk(6'd24, 32'h0000_0800, 1, 1, 0, 3,  0, 1, 1, 0, 0, 0,    1,      1,   1);
    vecs[8]  = mk(6'd53, 32'hFFFF_FFFF, 1, 1, 1, 0,  0, 2, 0, 0, 0, 0,    1,      0,   1);
    vecs[9]  = mk(6'd25, 32'h0000_0042, 1, 1, 1, 2,  5, 1, 2, 0, 0, AUTO, 1+AUTO, 1,   1-AUTO);
    vecs[10] = mk(6'd9,  32'h8000_0000, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0,    1,      0,   1);

    // Outputs held at zero during reset
    repeat (3) @(posedge clock);
    #1;
    chk("reset outputs", 64'({bus.busy, bus.new_command, bus.new_data, bus.xfer_done,
        bus.err_status, bus.cmd_index_o, bus.cmd_argument_o, bus.write_read_o,
        bus.multiple_o, bus.block_count_o}), 64'd0);
    reset = 1'b1;
    step();

    // Completes while idle are ignored
    bus.command_complete = 1; bus.data_complete = 1;
    step();
    bus.command_complete = 0; bus.data_complete = 0;
    acc = 0;
    repeat (3) begin
      acc += int'(bus.busy) + int'(bus.xfer_done) + int'(bus.new_command);
      step();
    end
    chk("idle completes ignored", 64'(acc), 64'd0);

    for (int i = 0; i < 11; i++) begin
      model(vecs[i], m_err, m_ncmd, m_ndat, m_done, m_blen);
      run_txn(vecs[i], vecs[i].e_err, vecs[i].e_ncmd, vecs[i].e_ndat, vecs[i].e_done,
              m_blen, $sformatf("vec%0d", i));
    end

    // Complete during ISSUE_CMD and start while busy are both ignored
    bus.cmd_index_i = 6'd3; bus.argument_i = 32'd77; bus.data_present = 0;
    bus.timeout_limit = TO_W'(4); bus.start = 1;
    step();
    bus.start = 0;
    chk("issue pulse", 64'(bus.new_command), 64'd1);
    bus.command_complete = 1; bus.start = 1; bus.cmd_index_i = 6'd9;
    step();
    bus.command_complete = 0; bus.start = 0;
    chk("index held after ignored start", 64'(bus.cmd_index_o), 64'd3);
    blen_c = 0; ncmd_c = 0; done_c = 0;
    for (int i = 0; i < 20 && bus.busy; i++) begin
      blen_c++;
      ncmd_c += int'(bus.new_command);
      done_c += int'(bus.xfer_done);
      step();
    end
    chk("issue-complete wait+error cycles", 64'(blen_c), 64'd5);
    chk("issue-complete err_status", 64'(bus.err_status), 64'd1);
    chk("issue-complete extra commands", 64'(ncmd_c), 64'd0);
    chk("issue-complete no done", 64'(done_c), 64'd0);

    for (int i = 0; i < 40; i++) begin
      v = mk(6'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 10)),
             int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
             int'($urandom_range(1, 12)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0,
             0, 0, 0, 0);
      model(v, m_err, m_ncmd, m_ndat, m_done, m_blen);
      run_txn(v, m_err, m_ncmd, m_ndat, m_done, m_blen, $sformatf("rnd%0d", i));
    end

    // Reset during WAIT_CMD abandons the transaction
    bus.cmd_index_i = 6'd5; bus.data_present = 0; bus.timeout_limit = '0; bus.start = 1;
    step();
    bus.start = 0;
    step();
    step();
    chk("busy before reset", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("outputs during mid reset", 64'({bus.busy, bus.new_command, bus.new_data,
        bus.xfer_done, bus.err_status, bus.cmd_index_o, bus.cmd_argument_o,
        bus.write_read_o, bus.multiple_o, bus.block_count_o}), 64'd0);
    step();
    reset = 1'b1;
    bus.command_complete = 1;
    step();
    bus.command_complete = 0;
    acc = 0;
    repeat (4) begin
      acc += int'(bus.busy) + int'(bus.xfer_done) + int'(bus.new_command);
      step();
    end
    chk("complete after reset ignored", 64'(acc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
